// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Issue-stage write scoreboard. It holds one pending-write counter for each of
//   the 32 architectural registers. An instruction is stalled while one of its
//   sources has an outstanding write (RAW), or while its destination counter is
//   saturated (WAW). Write-back retires one pending write per cycle.
//
// Optional feature (macro SCOREBOARD_BYPASS_EN):
//   When defined, a write-back completing this cycle is subtracted before the
//   hazard check, so a dependent instruction issues in that same cycle.
//   When undefined, the hazard check uses the registered counts only, and the
//   dependent instruction issues one cycle after the write-back.
//
// Opcode encodings come from `INSTR_LOAD, `INSTR_STORE and `INSTR_ALU_OP. If the
// surrounding build has not defined them, they get local default values here.
//
// Ports:
//   clk, rst            clock; synchronous active-high reset
//   issue_valid, instr  instruction at issue (opcode in instr[31:27])
//   reads_k, read_reg_k source-operand flags and register numbers (k = 0, 1)
//   wb_valid, wb_reg    write-back completion
//   stall, issue_fire   combinational issue control
//   busy_mask           bit r set while register r has pending writes
//   err_underflow       sticky; write-back seen for a register with no pending write

`ifndef INSTR_LOAD
`define INSTR_LOAD   5'b00001
`endif
`ifndef INSTR_STORE
`define INSTR_STORE  5'b00010
`endif
`ifndef INSTR_ALU_OP
`define INSTR_ALU_OP 5'b00011
`endif

module reg_scoreboard #(
    parameter int CNT_W = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic [31:0] instr,
    input  logic        reads_0,
    input  logic        reads_1,
    input  logic [4:0]  read_reg_0,
    input  logic [4:0]  read_reg_1,
    input  logic        wb_valid,
    input  logic [4:0]  wb_reg,
    output logic        stall,
    output logic        issue_fire,
    output logic [31:0] busy_mask,
    output logic        err_underflow
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] count   [32];
    logic [CNT_W-1:0] eff_cnt [32];
    logic [4:0]       opcode;
    logic             writes;
    logic [4:0]       dest;
    logic             raw_0;
    logic             raw_1;
    logic             waw;
    logic             unused_instr;

    assign opcode       = instr[31:27];
    assign unused_instr = ^{instr[26:22], instr[11:0]};

    // Destination decode; STORE and unknown opcodes write nothing.
    always_comb begin
        writes = 1'b0;
        dest   = 5'd0;
        if (opcode == `INSTR_LOAD) begin
            writes = 1'b1;
            dest   = instr[21:17];
        end else if (opcode == `INSTR_ALU_OP) begin
            writes = 1'b1;
            dest   = instr[16:12];
        end
    end

    // Count used by the hazard check.
    always_comb begin
        for (int r = 0; r < 32; r++) begin
`ifdef SCOREBOARD_BYPASS_EN
            if (wb_valid && (wb_reg == 5'(r)) && (count[r] != '0))
                eff_cnt[r] = count[r] - 1'b1;
            else
                eff_cnt[r] = count[r];
`else
            eff_cnt[r] = count[r];
`endif
        end
    end

    assign raw_0      = issue_valid & reads_0 & (eff_cnt[read_reg_0] != '0);
    assign raw_1      = issue_valid & reads_1 & (eff_cnt[read_reg_1] != '0);
    assign waw        = issue_valid & writes  & (eff_cnt[dest] == CNT_MAX);
    assign stall      = raw_0 | raw_1 | waw;
    assign issue_fire = issue_valid & ~stall;

    always_comb begin
        for (int r = 0; r < 32; r++)
            busy_mask[r] = (count[r] != '0);
    end

    // Counter update: an increment and a decrement on the same register in the
    // same cycle cancel. Saturation is prevented by the WAW stall, so the
    // increment never wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < 32; r++)
                count[r] <= '0;
            err_underflow <= 1'b0;
        end else begin
            for (int r = 0; r < 32; r++) begin
                logic inc;
                logic dec;
                inc = issue_fire & writes & (dest == 5'(r));
                dec = wb_valid & (wb_reg == 5'(r)) & (count[r] != '0);
                if (inc && !dec)
                    count[r] <= count[r] + 1'b1;
                else if (dec && !inc)
                    count[r] <= count[r] - 1'b1;
            end
            if (wb_valid && (count[wb_reg] == '0))
                err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_reg_scoreboard.sv
// Testbench for reg_scoreboard. Stimulus queues the expected output values for
// each cycle; a monitor on the falling edge pops and compares them.

`ifndef INSTR_LOAD
`define INSTR_LOAD   5'b00001
`endif
`ifndef INSTR_STORE
`define INSTR_STORE  5'b00010
`endif
`ifndef INSTR_ALU_OP
`define INSTR_ALU_OP 5'b00011
`endif

module tb_reg_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid;
    logic [31:0] instr;
    logic        reads_0, reads_1;
    logic [4:0]  read_reg_0, read_reg_1;
    logic        wb_valid;
    logic [4:0]  wb_reg;
    logic        stall, issue_fire, err_underflow;
    logic [31:0] busy_mask;

    reg_scoreboard #(.CNT_W(2)) dut (
        .clk(clk), .rst(rst), .issue_valid(issue_valid), .instr(instr),
        .reads_0(reads_0), .reads_1(reads_1),
        .read_reg_0(read_reg_0), .read_reg_1(read_reg_1),
        .wb_valid(wb_valid), .wb_reg(wb_reg),
        .stall(stall), .issue_fire(issue_fire),
        .busy_mask(busy_mask), .err_underflow(err_underflow)
    );

    always #5 clk = ~clk;

    localparam int SEL_STALL = 0, SEL_FIRE = 1, SEL_BUSY = 2, SEL_ERR = 3;

    typedef struct {
        int          cyc;
        int          sel;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   done = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            logic [31:0] act;
            e = q.pop_front();
            case (e.sel)
                SEL_STALL: act = {31'd0, stall};
                SEL_FIRE:  act = {31'd0, issue_fire};
                SEL_BUSY:  act = busy_mask;
                default:   act = {31'd0, err_underflow};
            endcase
            checks++;
            if (e.cyc != cyc || act !== e.exp) begin
                failures++;
                $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.exp);
            end
        end
    end

    function automatic logic [31:0] alu(input logic [4:0] d);
        return {`INSTR_ALU_OP, 10'd0, d, 12'd0};
    endfunction
    function automatic logic [31:0] load(input logic [4:0] d);
        return {`INSTR_LOAD, 5'd0, d, 17'd0};
    endfunction
    function automatic logic [31:0] store();
        return {`INSTR_STORE, 27'd0};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic iv, input logic [31:0] ins,
                         input logic r0, input logic [4:0] rr0,
                         input logic r1, input logic [4:0] rr1,
                         input logic wbv, input logic [4:0] wbr);
        issue_valid = iv; instr = ins;
        reads_0 = r0; read_reg_0 = rr0;
        reads_1 = r1; read_reg_1 = rr1;
        wb_valid = wbv; wb_reg = wbr;
    endtask

    task automatic idle();
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    task automatic expect_v(input string name, input int sel, input logic [31:0] v);
        exp_t e;
        e.cyc = cyc; e.sel = sel; e.exp = v; e.name = name;
        q.push_back(e);
    endtask

    task automatic expect_issue(input string name, input logic st);
        expect_v({name, "_stall"}, SEL_STALL, {31'd0, st});
        expect_v({name, "_fire"},  SEL_FIRE,  {31'd0, ~st});
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        step();
        rst = 1'b0;

        // Reset state
        expect_v("rst_busy", SEL_BUSY, 32'h0);
        expect_v("rst_err",  SEL_ERR,  32'h0);
        expect_v("rst_idle_stall", SEL_STALL, 32'h0);
        step();

        // ALU_OP writing r5 issues with nothing busy
        drive(1'b1, alu(5'd5), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_issue("alu5", 1'b0);
        step();

        // Dependent ALU_OP (reads r5, writes r6) stalls
        drive(1'b1, alu(5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_v("busy_r5", SEL_BUSY, 32'h0000_0020);
        expect_issue("raw_wait", 1'b1);
        step();

        // Cycle N: write-back of r5 arrives
        drive(1'b1, alu(5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5);
        expect_v("busy_r5_at_wb", SEL_BUSY, 32'h0000_0020);
`ifdef SCOREBOARD_BYPASS_EN
        expect_issue("raw_wb_bypass", 1'b0);
        step();
        idle();
        expect_v("busy_after_bypass_issue", SEL_BUSY, 32'h0000_0040);
        step();
`else
        expect_issue("raw_wb_nobypass", 1'b1);
        step();
        drive(1'b1, alu(5'd6), 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_v("busy_r5_cleared", SEL_BUSY, 32'h0);
        expect_issue("raw_after_wb", 1'b0);
        step();
`endif
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd6);
        expect_v("busy_r6", SEL_BUSY, 32'h0000_0040);
        step();
        idle();
        expect_v("busy_clear", SEL_BUSY, 32'h0);
        step();

        // WAW saturation on r7
        drive(1'b1, load(5'd7), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_issue("load7_1", 1'b0);
        step();
        expect_issue("load7_2", 1'b0);
        expect_v("busy_r7", SEL_BUSY, 32'h0000_0080);
        step();
        expect_issue("load7_3", 1'b0);
        step();
        expect_issue("load7_sat", 1'b1);
        expect_v("busy_r7_sat", SEL_BUSY, 32'h0000_0080);
        step();
        drive(1'b1, load(5'd7), 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
`ifdef SCOREBOARD_BYPASS_EN
        expect_issue("load7_sat_wb", 1'b0);
        step();
        // count stays at 3: three retirements needed
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
            expect_v("busy_r7_drain", SEL_BUSY, 32'h0000_0080);
            step();
        end
`else
        expect_issue("load7_sat_wb", 1'b1);
        step();
        // count dropped to 2: two retirements needed
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7);
            expect_v("busy_r7_drain", SEL_BUSY, 32'h0000_0080);
            step();
        end
`endif
        idle();
        expect_v("busy_r7_empty", SEL_BUSY, 32'h0);
        expect_v("no_underflow", SEL_ERR, 32'h0);
        step();

        // STORE reading idle r3, r4
        drive(1'b1, store(), 1'b1, 5'd3, 1'b1, 5'd4, 1'b0, 5'd0);
        expect_issue("store", 1'b0);
        step();
        idle();
        expect_v("store_busy", SEL_BUSY, 32'h0);
        step();

        // Underflow on r9
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9);
        expect_v("uf_before", SEL_ERR, 32'h0);
        step();
        idle();
        expect_v("uf_set", SEL_ERR, 32'h1);
        expect_v("uf_busy", SEL_BUSY, 32'h0);
        step();
        expect_v("uf_sticky", SEL_ERR, 32'h1);
        step();

        // Mid-operation reset with three writes to r2 pending
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, alu(5'd2), 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
            expect_issue("alu2", 1'b0);
            step();
        end
        idle();
        expect_v("busy_r2", SEL_BUSY, 32'h0000_0004);
        rst = 1'b1;
        step();
        rst = 1'b0;
        expect_v("rst2_busy", SEL_BUSY, 32'h0);
        expect_v("rst2_err", SEL_ERR, 32'h0);
        drive(1'b1, alu(5'd0), 1'b1, 5'd2, 1'b0, 5'd0, 1'b0, 5'd0);
        expect_issue("read_r2_after_rst", 1'b0);
        step();
        // Stale write-back for a pre-reset issue
        drive(1'b0, 32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2);
        step();
        idle();
        expect_v("stale_wb_err", SEL_ERR, 32'h1);
        step();

        // Drain the expectation queue within a bounded number of cycles
        for (int i = 0; i < 10 && q.size() > 0; i++) step();
        while (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            failures++;
            $display("FAIL %s: never compared, expected %h", e.name, e.exp);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        done = 1'b1;
        $finish;
    end

    initial begin
        #200000;
        if (!done) begin
            $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
            $fatal(1, "watchdog");
        end
    end

endmodule
